rx_port_arbiter: RTL and testbench

Round-robin arbiter that shares one 32-bit valid/ready receive sink (the `rx2`-class capture block) between up to `N_REQ` transmitters. A grant lasts for one burst, which is the contiguous period a requester holds `valid` high. The arbiter enforces an idle gap on `out_valid` between bursts so the sink sees a clean falling and rising `valid` edge for every burst. It sits between the transmitter ports and the single receiver instance and owns all `ready` routing.

---
 rtl/rx_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 32 +++
 rtl/rx_port_arbiter.sv | 105 ++++++++++
 tb/tb_rx_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_arb_pkg.sv
// Shared types and constants for the receive-port arbiter.
// Carries the FSM state encoding, data width and beat counter helpers.
package rx_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2
    } arb_state_e;

    localparam int RX_DW   = 32;
    localparam int BEAT_CW = 16;

    function automatic logic [BEAT_CW-1:0] beat_sat_inc(input logic [BEAT_CW-1:0] v);
        return (v == {BEAT_CW{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request searching upward from last+1, wrapping at N_REQ-1.
// Purely combinational, zero latency; no flow control of its own.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    last_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o
);

    logic found;
    int   k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        k     = 0;
        // Offsets 1..N_REQ visit every requester once, the previous winner last.
        for (int off = 1; off <= N_REQ; off++) begin
            k = (int'(last_i) + off) % N_REQ;
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/rx_port_arbiter.sv
// Shares one valid/ready sink among N_REQ transmitters, one burst per grant, with a forced idle gap.
// Grant one edge after request; data/valid/ready pass through combinationally; out_ready low stalls the grant indefinitely.
module rx_port_arbiter
    import rx_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = RX_DW,
    parameter int GAP       = 1,
    parameter int MAX_BEATS = 256,
    parameter int IW        = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*DW-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
    input  logic                  out_ready,
    output logic [IW-1:0]         grant_id,
    output logic                  busy,
    output logic [BEAT_CW-1:0]    beat_cnt
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    arb_state_e         state_q;
    logic [IW-1:0]      grant_q;
    logic [IW-1:0]      last_q;
    logic [BEAT_CW-1:0] beat_q;
    logic [BEAT_CW-1:0] beat_d;
    logic [GW-1:0]      gap_q;

    logic [N_REQ-1:0]   pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    logic               g_valid;
    logic [DW-1:0]      g_data;
    logic               beat;
    logic               cap_hit;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req_i  (req_valid),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx)
    );

    assign pick_any = |pick_gnt;

    assign g_valid   = req_valid[grant_q];
    assign g_data    = req_data[int'(grant_q)*DW +: DW];
    assign busy      = (state_q == S_BUSY);
    assign out_valid = busy & g_valid;
    assign out_data  = out_valid ? g_data : '0;
    assign req_ready = busy ? (N_REQ'(out_ready) << grant_q) : '0;
    assign beat      = out_valid & out_ready;
    assign cap_hit   = (MAX_BEATS != 0) && (beat_q == BEAT_CW'(MAX_BEATS - 1));
    assign beat_d    = beat ? beat_sat_inc(beat_q) : beat_q;

    assign grant_id  = grant_q;
    assign beat_cnt  = beat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= IW'(N_REQ - 1);
            beat_q  <= '0;
            gap_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        last_q  <= pick_idx;
                        beat_q  <= '0;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    beat_q <= beat_d;
                    // A capped burst still accepts its final beat on this edge.
                    if (!g_valid || (beat && cap_hit)) begin
                        gap_q   <= '0;
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q == GW'(GAP - 1)) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_port_arbiter.sv
// Directed bench for rx_port_arbiter: transmitter models drive bursts, a monitor scores every sink beat and gap.
module tb_rx_port_arbiter;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_ready;
    logic [1:0]      grant_id;
    logic            busy;
    logic [15:0]     beat_cnt;

    always #5 clk = ~clk;

    rx_port_arbiter #(
        .N_REQ     (N),
        .DW        (DW),
        .GAP       (1),
        .MAX_BEATS (MAXB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .beat_cnt  (beat_cnt)
    );

    typedef struct {
        logic [1:0]  id;
        logic [31:0] dat;
        logic [15:0] cnt;
    } beat_t;

    beat_t       bq[$];
    int          gq[$];
    int          rem[N];
    logic [31:0] nd[N];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h expected nothing at %0t", nm, act, $time);
    endtask

    task automatic push_run(input int id, input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            beat_t b;
            b.id  = 2'(id);
            b.dat = base + 32'(k);
            b.cnt = 16'(k);
            bq.push_back(b);
        end
    endtask

    task automatic push_gap(input int n);
        gq.push_back(n);
    endtask

    task automatic set_req(input int id, input int n, input logic [31:0] base);
        rem[id] = n;
        nd[id]  = base;
    endtask

    // Caller positions this just after a rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) rem[i] = 0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_done(input string nm, input int budget);
        for (int c = 0; c < budget && (bq.size() != 0 || gq.size() != 0); c++) @(negedge clk);
        chk(nm, 32'(bq.size() + gq.size()), 32'd0);
        repeat (6) @(posedge clk);
    endtask

    // Transmitters: advance data on each accepted beat, drop valid when their count runs out.
    initial begin
        logic [N-1:0] fire;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            nd[i]  = '0;
        end
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            fire = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (fire[i]) begin
                    rem[i] = rem[i] - 1;
                    nd[i]  = nd[i] + 32'd1;
                end
            end
            #2;
            for (int i = 0; i < N; i++) begin
                req_valid[i]          = (rem[i] > 0);
                req_data[i*DW +: DW]  = (rem[i] > 0) ? nd[i] : 32'd0;
            end
        end
    end

    // Sink-side monitor.
    initial begin
        bit seen_high;
        int low_run;
        beat_t e;
        seen_high = 1'b0;
        low_run   = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen_high = 1'b0;
                low_run   = 0;
            end else begin
                chk("rdy_route", 32'(req_ready), busy ? 32'(4'(out_ready) << grant_id) : 32'd0);
                if (!out_valid) begin
                    chk("idle_data_zero", out_data, 32'd0);
                    if (seen_high) low_run++;
                end else begin
                    if (seen_high && low_run > 0) begin
                        if (gq.size() == 0) flag("unexpected_gap", 32'(low_run));
                        else chk("gap_len", 32'(low_run), 32'(gq.pop_front()));
                    end
                    seen_high = 1'b1;
                    low_run   = 0;
                    if (out_ready) begin
                        if (bq.size() == 0) begin
                            flag("unexpected_beat", out_data);
                        end else begin
                            e = bq.pop_front();
                            chk("beat_id", 32'(grant_id), 32'(e.id));
                            chk("beat_dat", out_data, e.dat);
                            chk("beat_cnt", 32'(beat_cnt), 32'(e.cnt));
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #2;
        do_reset();

        // T1: requesters 1 and 2 together; 1 wins, 2 follows after valid drop + gap.
        @(posedge clk); #2;
        set_req(1, 3, 32'h100);
        set_req(2, 2, 32'h200);
        push_run(1, 32'h100, 3);
        push_gap(3);
        push_run(2, 32'h200, 2);
        @(negedge clk);
        chk("t1_pre_busy", 32'(busy), 32'd0);
        chk("t1_pre_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_grant", 32'(grant_id), 32'd1);
        wait_done("t1_drain", 200);
        chk("t1_last_grant", 32'(grant_id), 32'd2);
        chk("t1_end_busy", 32'(busy), 32'd0);
        chk("t1_end_cnt", 32'(beat_cnt), 32'd2);

        // T2: requester 0 with 5 beats, capped at 4, then rearbitrates alone.
        @(posedge clk); #2;
        do_reset();
        @(posedge clk); #2;
        set_req(0, 5, 32'hA0);
        push_run(0, 32'hA0, 4);
        push_gap(2);
        push_run(0, 32'hA4, 1);
        wait_done("t2_drain", 200);
        chk("t2_end_cnt", 32'(beat_cnt), 32'd1);
        chk("t2_grant", 32'(grant_id), 32'd0);

        // T3: requester 3 long burst with requester 1 waiting.
        @(posedge clk); #2;
        do_reset();
        @(posedge clk); #2;
        set_req(3, 10, 32'h300);
        push_run(3, 32'h300, 4);
        push_gap(2);
        push_run(1, 32'h110, 3);
        push_gap(3);
        push_run(3, 32'h304, 4);
        push_gap(2);
        push_run(3, 32'h308, 2);
        @(posedge clk); #2;
        set_req(1, 3, 32'h110);
        @(negedge clk);
        chk("t3_grant", 32'(grant_id), 32'd3);
        chk("t3_busy", 32'(busy), 32'd1);
        wait_done("t3_drain", 300);

        // T4: out_ready pattern 1,0,0,1 while requester 2 holds valid.
        @(posedge clk); #2;
        do_reset();
        @(posedge clk); #2;
        set_req(2, 3, 32'h220);
        push_run(2, 32'h220, 3);
        push_gap(3);
        push_run(0, 32'hF0, 1);
        @(posedge clk); #2;
        set_req(0, 1, 32'hF0);
        @(posedge clk); #2;
        out_ready = 1'b0;
        @(negedge clk);
        chk("t4_stall_cnt_a", 32'(beat_cnt), 32'd1);
        chk("t4_stall_rdy", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("t4_stall_cnt_b", 32'(beat_cnt), 32'd1);
        chk("t4_stall_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #2;
        out_ready = 1'b1;
        wait_done("t4_drain", 200);

        // T5: all four requesting, each capped; rotation 0,1,2,3,0.
        @(posedge clk); #2;
        do_reset();
        @(posedge clk); #2;
        set_req(0, 5, 32'h5000);
        set_req(1, 4, 32'h5010);
        set_req(2, 4, 32'h5020);
        set_req(3, 4, 32'h5030);
        push_run(0, 32'h5000, 4);
        push_gap(2);
        push_run(1, 32'h5010, 4);
        push_gap(2);
        push_run(2, 32'h5020, 4);
        push_gap(2);
        push_run(3, 32'h5030, 4);
        push_gap(2);
        push_run(0, 32'h5004, 1);
        wait_done("t5_drain", 400);

        // T6: reset pulse mid-burst, then requester 0 wins first.
        @(posedge clk); #2;
        do_reset();
        @(posedge clk); #2;
        set_req(1, 20, 32'h600);
        push_run(1, 32'h600, 2);
        repeat (3) @(posedge clk);
        #2;
        do_reset();
        @(posedge clk); #2;
        set_req(0, 1, 32'h700);
        set_req(2, 1, 32'h720);
        push_run(0, 32'h700, 1);
        push_gap(3);
        push_run(2, 32'h720, 1);
        @(negedge clk);
        @(negedge clk);
        chk("t6_first_grant", 32'(grant_id), 32'd0);
        chk("t6_busy", 32'(busy), 32'd1);
        wait_done("t6_drain", 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
